// File: rtl/tt_sel_pkg.sv
// Shared types and default widths for the design-select pad sequencer.
package tt_sel_pkg;

  localparam int ADDR_W_DEF  = 10;
  localparam int PULSE_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RST_LO = 3'd1,
    RST_HI = 3'd2,
    INC_HI = 3'd3,
    INC_LO = 3'd4,
    FINISH = 3'd5
  } sel_state_t;

endpackage

// File: rtl/tt_sel_phase_timer.sv
// Phase timer: loads T-1, counts down to zero and flags the last cycle of a phase.
module tt_sel_phase_timer #(
  parameter int PULSE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [PULSE_W-1:0] load_val,
  output logic               expired
);

  logic [PULSE_W-1:0] count;

  // Holding at zero keeps expired asserted until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/tt_sel_seq.sv
// Drives the design-select pads: timed selector reset, req_addr increment
// pulses, then optional design enable.
module tt_sel_seq
  import tt_sel_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int PULSE_W = PULSE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic               req_ena,
  input  logic [PULSE_W-1:0] half_period,
  input  logic               abort,
  output logic               ctrl_sel_rst_n,
  output logic               ctrl_sel_inc,
  output logic               ctrl_ena,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  cur_addr
);

  sel_state_t         state;
  logic [ADDR_W-1:0]  remaining;
  logic [PULSE_W-1:0] t_m1;
  logic               ena_q;
  logic [PULSE_W-1:0] hp_m1;
  logic               timer_load;
  logic [PULSE_W-1:0] timer_val;
  logic               timer_expired;

  // half_period of 0 is treated as 1, so the loaded count is max(hp,1)-1.
  assign hp_m1 = (half_period == '0) ? '0 : half_period - 1'b1;

  // Reloading every idle cycle and at every expiry starts each phase with T-1.
  assign timer_load = (state == IDLE) || timer_expired;
  assign timer_val  = (state == IDLE) ? hp_m1 : t_m1;

  tt_sel_phase_timer #(.PULSE_W(PULSE_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_expired)
  );

  assign busy      = (state != IDLE);
  assign req_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ctrl_sel_rst_n <= 1'b1;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
      done           <= 1'b0;
      cur_addr       <= '0;
      remaining      <= '0;
      t_m1           <= '0;
      ena_q          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Abort beats any accept; cur_addr keeps the completed pulse count.
        state          <= IDLE;
        ctrl_sel_rst_n <= 1'b1;
        ctrl_sel_inc   <= 1'b0;
        ctrl_ena       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              ctrl_ena       <= 1'b0;
              ctrl_sel_rst_n <= 1'b0;
              cur_addr       <= '0;
              remaining      <= req_addr;
              t_m1           <= hp_m1;
              ena_q          <= req_ena;
              state          <= RST_LO;
            end
          end
          RST_LO: begin
            if (timer_expired) begin
              ctrl_sel_rst_n <= 1'b1;
              state          <= RST_HI;
            end
          end
          RST_HI, INC_LO: begin
            if (timer_expired) begin
              if (remaining == '0) begin
                state <= FINISH;
              end else begin
                ctrl_sel_inc <= 1'b1;
                state        <= INC_HI;
              end
            end
          end
          INC_HI: begin
            if (timer_expired) begin
              ctrl_sel_inc <= 1'b0;
              cur_addr     <= cur_addr + 1'b1;
              remaining    <= remaining - 1'b1;
              state        <= INC_LO;
            end
          end
          FINISH: begin
            ctrl_ena <= ena_q;
            done     <= 1'b1;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tt_sel_seq.sv
// Self-checking bench for tt_sel_seq: directed vector table, corner sequences
// and randomized requests against a cycle-indexed waveform model.
module tb_tt_sel_seq;
  import tt_sel_pkg::*;

  localparam int AW = ADDR_W_DEF;
  localparam int PW = PULSE_W_DEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_ena;
  logic [PW-1:0] half_period;
  logic          abort;
  logic          ctrl_sel_rst_n;
  logic          ctrl_sel_inc;
  logic          ctrl_ena;
  logic          busy;
  logic          done;
  logic [AW-1:0] cur_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tt_sel_seq #(.ADDR_W(AW), .PULSE_W(PW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_ena        (req_ena),
    .half_period    (half_period),
    .abort          (abort),
    .ctrl_sel_rst_n (ctrl_sel_rst_n),
    .ctrl_sel_inc   (ctrl_sel_inc),
    .ctrl_ena       (ctrl_ena),
    .busy           (busy),
    .done           (done),
    .cur_addr       (cur_addr)
  );

  typedef struct {
    int hp;
    int addr;
    bit ena;
    int cut_kind;
    int cut_at;
    int exp_lat;
    int exp_cur;
    bit exp_ena;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  function automatic logic [15:0] dut_bundle();
    return {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, busy, done, req_ready, cur_addr};
  endfunction

  // Expected pads k edges after the accept edge, straight from the pulse timeline.
  function automatic logic [15:0] model(int t, int addr, bit ena, int k);
    int  lat;
    int  cur;
    bit  rstn, inc, bsy, dn, e;
    lat  = 2 * t * (addr + 1) + 1;
    rstn = !(k < t);
    inc  = 1'b0;
    if (k >= 2 * t && k < 2 * t * (addr + 1))
      inc = ((k - 2 * t) % (2 * t)) < t;
    cur = (k < 3 * t) ? 0 : (k - 3 * t) / (2 * t) + 1;
    if (cur > addr) cur = addr;
    bsy = k < lat;
    dn  = (k == lat);
    e   = (k >= lat) ? ena : 1'b0;
    return {rstn, inc, e, bsy, dn, !bsy, 10'(cur)};
  endfunction

  // cut_kind: 0 none, 1 abort, 2 sync reset; cut_at is the edge that samples it.
  task automatic applyStimulus(input int hp, input int addr, input bit ena,
                               input int cut_kind, input int cut_at,
                               output int lat_seen, output int cur_end, output bit ena_end);
    int t, lat, last;
    logic [15:0] exp_v, prev_v;
    t    = (hp == 0) ? 1 : hp;
    lat  = 2 * t * (addr + 1) + 1;
    last = (cut_kind != 0) ? cut_at : lat + 1;
    lat_seen = -1;
    checkOutput("ready_before_accept", 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_addr    = AW'(addr);
    req_ena     = ena;
    half_period = PW'(hp);
    prev_v      = '0;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (cut_kind == 1 && k == cut_at)
        exp_v = {6'b100001, prev_v[9:0]};
      else if (cut_kind == 2 && k == cut_at)
        exp_v = {6'b100001, 10'd0};
      else
        exp_v = model(t, addr, ena, k);
      prev_v = model(t, addr, ena, k);
      checkOutput($sformatf("seq_hp%0d_a%0d_k%0d", hp, addr, k), 32'(dut_bundle()), 32'(exp_v));
      if (done === 1'b1 && lat_seen < 0) lat_seen = k;
      req_valid = 1'b0;
      abort     = 1'b0;
      rst       = 1'b0;
      if (k + 1 < lat && (cut_kind == 0 || k + 1 < cut_at)) begin
        req_valid   = 1'($urandom);
        req_addr    = AW'($urandom);
        req_ena     = 1'($urandom);
        half_period = PW'($urandom);
      end
      if (cut_kind == 1 && k + 1 == cut_at) abort = 1'b1;
      if (cut_kind == 2 && k + 1 == cut_at) rst = 1'b1;
    end
    req_valid = 1'b0;
    abort     = 1'b0;
    rst       = 1'b0;
    cur_end   = int'(cur_addr);
    ena_end   = ctrl_ena;
  endtask

  initial begin
    int lat_seen, cur_end;
    bit ena_end;
    int hp, addr, t, lat, kind, cut;
    bit ena;

    vecs[0] = '{1,    3,    1'b1, 0, 0,  9,    3,    1'b1};
    vecs[1] = '{1,    2,    1'b0, 0, 0,  7,    2,    1'b0};
    vecs[2] = '{4,    0,    1'b1, 0, 0,  9,    0,    1'b1};
    vecs[3] = '{0,    3,    1'b1, 0, 0,  9,    3,    1'b1};
    vecs[4] = '{2,    5,    1'b1, 1, 11, -1,   2,    1'b0};
    vecs[5] = '{255,  1,    1'b1, 0, 0,  1021, 1,    1'b1};
    vecs[6] = '{3,    2,    1'b1, 2, 7,  -1,   0,    1'b0};
    vecs[7] = '{1,    1023, 1'b1, 0, 0,  2049, 1023, 1'b1};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_ena = 1'b0;
    half_period = '0; abort = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_values", 32'(dut_bundle()), 32'({6'b100001, 10'd0}));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].hp, vecs[i].addr, vecs[i].ena, vecs[i].cut_kind,
                    vecs[i].cut_at, lat_seen, cur_end, ena_end);
      checkOutput($sformatf("latency_v%0d", i), 32'(lat_seen), 32'(vecs[i].exp_lat));
      checkOutput($sformatf("cur_addr_v%0d", i), 32'(cur_end), 32'(vecs[i].exp_cur));
      checkOutput($sformatf("ena_v%0d", i), 32'(ena_end), 32'(vecs[i].exp_ena));
      repeat (3) @(negedge clk);
      checkOutput($sformatf("ena_hold_v%0d", i), 32'(ctrl_ena), 32'(vecs[i].exp_ena));
    end

    // abort together with req_valid in IDLE: no accept, only ctrl_ena clears
    req_valid = 1'b1; abort = 1'b1; req_addr = AW'(5); half_period = PW'(1);
    @(negedge clk);
    req_valid = 1'b0; abort = 1'b0;
    checkOutput("abort_wins_idle", 32'(dut_bundle()), 32'({6'b100001, 10'd1023}));
    @(negedge clk);
    checkOutput("abort_wins_still_idle", 32'(busy), 32'd0);

    for (int r = 0; r < 14; r++) begin
      hp   = $urandom_range(0, 6);
      addr = $urandom_range(0, 7);
      ena  = 1'($urandom);
      t    = (hp == 0) ? 1 : hp;
      lat  = 2 * t * (addr + 1) + 1;
      kind = ($urandom_range(0, 3) == 0) ? 1 : 0;
      cut  = (kind == 1) ? $urandom_range(1, lat) : 0;
      applyStimulus(hp, addr, ena, kind, cut, lat_seen, cur_end, ena_end);
      if (kind == 0)
        checkOutput($sformatf("rand_latency_%0d", r), 32'(lat_seen), 32'(lat));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
